// File: rtl/dma_bus_arbiter.sv
// dma_bus_arbiter: sequences ownership of the system address bus / RW line
// between the 6502 core (default owner), MARIA DMA and the ROM/RAM loader.
// Every hand-off is aligned to pclk_0 rising edges: the CPU is halted first,
// a fixed number of phase edges pass, then the new owner is granted. The bus
// is returned to the CPU the same way.
module dma_bus_arbiter #(
  parameter int HALT_SETUP = 2,    // pclk_0 rising edges from halt to grant (1..7)
  parameter int MAX_DMA    = 1023  // DMA grant length before forced release (1..65535)
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        pclk_0,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rw,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic        ld_req,
  input  logic [15:0] ld_addr,
  input  logic        ld_we,
  input  logic        timeout_clr,
  output logic [15:0] AB,
  output logic        RW,
  output logic        halt_b,
  output logic        dma_grant,
  output logic        ld_grant,
  output logic [1:0]  owner,
  output logic        timeout
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HALT_WAIT = 2'd1,
    GRANT     = 2'd2,
    RELEASE   = 2'd3
  } state_t;

  localparam logic [2:0]  ECNT_LAST = 3'(HALT_SETUP - 1);
  localparam logic [15:0] WCNT_LAST = 16'(MAX_DMA - 1);

  localparam logic [1:0] OWN_CPU = 2'd0;
  localparam logic [1:0] OWN_DMA = 2'd1;
  localparam logic [1:0] OWN_LD  = 2'd2;

  state_t      state_q, state_d;
  logic        sel_q, sel_d;          // 0 = DMA, 1 = loader
  logic [2:0]  ecnt_q, ecnt_d;        // phase edges seen while halting
  logic [15:0] wcnt_q, wcnt_d;        // DMA watchdog, saturating
  logic        halt_b_q, halt_b_d;
  logic        dma_grant_q, dma_grant_d;
  logic        ld_grant_q, ld_grant_d;
  logic [1:0]  owner_q, owner_d;
  logic        timeout_q, timeout_d;
  logic        pclk_0_q, pclk_0_d;

  logic        phi_rise;
  logic        sel_req;

  assign pclk_0_d = pclk_0;
  assign phi_rise = pclk_0 & ~pclk_0_q;
  // Request level of whichever requester won arbitration.
  assign sel_req  = sel_q ? ld_req : dma_req;

  // Next-state and registered-output logic for the hand-off sequencer.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ecnt_d      = ecnt_q;
    wcnt_d      = wcnt_q;
    halt_b_d    = halt_b_q;
    dma_grant_d = dma_grant_q;
    ld_grant_d  = ld_grant_q;
    owner_d     = owner_q;
    // Clear first so a watchdog set later in this block takes priority.
    timeout_d   = timeout_q & ~timeout_clr;

    case (state_q)
      IDLE: begin
        // Loader wins a tie.
        if (ld_req || dma_req) begin
          sel_d    = ld_req;
          state_d  = HALT_WAIT;
          halt_b_d = 1'b0;
          ecnt_d   = 3'd0;
        end
      end

      HALT_WAIT: begin
        if (!sel_req) begin
          // Requester gave up before its grant; hand the bus straight back.
          state_d = RELEASE;
        end else if (phi_rise) begin
          if (ecnt_q == ECNT_LAST) begin
            state_d     = GRANT;
            dma_grant_d = ~sel_q;
            ld_grant_d  = sel_q;
            owner_d     = sel_q ? OWN_LD : OWN_DMA;
            wcnt_d      = 16'd0;
          end else begin
            ecnt_d = ecnt_q + 3'd1;
          end
        end
      end

      GRANT: begin
        if (!sel_req) begin
          state_d     = RELEASE;
          dma_grant_d = 1'b0;
          ld_grant_d  = 1'b0;
          owner_d     = OWN_CPU;
        end else if (!sel_q) begin
          if (wcnt_q == WCNT_LAST) begin
            // Watchdog: DMA held the bus for MAX_DMA cycles.
            state_d     = RELEASE;
            dma_grant_d = 1'b0;
            owner_d     = OWN_CPU;
            timeout_d   = 1'b1;
          end else if (wcnt_q != 16'hFFFF) begin
            wcnt_d = wcnt_q + 16'd1;
          end
        end
      end

      RELEASE: begin
        if (phi_rise) begin
          halt_b_d = 1'b1;
          state_d  = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        halt_b_d    = 1'b1;
        dma_grant_d = 1'b0;
        ld_grant_d  = 1'b0;
        owner_d     = OWN_CPU;
      end
    endcase
  end

  // State and registered outputs; reset returns the bus to the CPU at once.
  always_ff @(posedge sysclk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sel_q       <= 1'b0;
      ecnt_q      <= 3'd0;
      wcnt_q      <= 16'd0;
      halt_b_q    <= 1'b1;
      dma_grant_q <= 1'b0;
      ld_grant_q  <= 1'b0;
      owner_q     <= OWN_CPU;
      timeout_q   <= 1'b0;
      pclk_0_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ecnt_q      <= ecnt_d;
      wcnt_q      <= wcnt_d;
      halt_b_q    <= halt_b_d;
      dma_grant_q <= dma_grant_d;
      ld_grant_q  <= ld_grant_d;
      owner_q     <= owner_d;
      timeout_q   <= timeout_d;
      pclk_0_q    <= pclk_0_d;
    end
  end

  // Bus mux: zero latency from the owner's address/rw, selected by registered state.
  always_comb begin
    AB = cpu_addr;
    RW = cpu_rw;
    if (state_q == GRANT) begin
      if (sel_q) begin
        AB = ld_addr;
        RW = ~ld_we;
      end else begin
        AB = dma_addr;
        RW = 1'b1;
      end
    end
  end

  assign halt_b    = halt_b_q;
  assign dma_grant = dma_grant_q;
  assign ld_grant  = ld_grant_q;
  assign owner     = owner_q;
  assign timeout   = timeout_q;

endmodule
